// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the TDM demultiplexer.
// Holds the alignment state enum and default channel geometry.
package tdm_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam int NCH_DEF = 4;
    localparam int SLOT_W  = $clog2(NCH_DEF);

endpackage

// File: rtl/tdm_chan_buf.sv
// tdm_chan_buf: one-entry valid/ready holding register for one channel.
// A write always wins; a drain without a write empties the entry.
module tdm_chan_buf
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: splits a framed TDM word stream into NCH channel buffers.
// Optional parity checking is compiled in with TDM_DEMUX_PARITY_EN.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = NCH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sof,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_par,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [$clog2(NCH)-1:0] slot,
    output logic                   locked,
    output logic                   sync_err,
    output logic                   par_err,
    output logic [7:0]             err_cnt
);

    localparam int SW = $clog2(NCH);

    state_t         state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic           sync_err_q, sync_err_d;
    logic [NCH-1:0] wr_en;
    logic           acc;
    logic           bad;
    logic           resync;

    assign locked   = (state_q == LOCKED);
    assign in_ready = locked ? (!out_valid[slot_q] | out_ready[slot_q])
                             : 1'b1;
    assign acc      = in_valid & in_ready;
    assign resync   = in_sof & (slot_q != '0);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_en      = '0;
        sync_err_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (acc && in_sof && !bad) begin
                    wr_en[0] = 1'b1;
                    state_d  = LOCKED;
                    slot_d   = SW'(1);
                end
            end
            LOCKED: begin
                if (acc && bad) begin
                    slot_d = slot_q + SW'(1);
                end else if (acc && resync) begin
                    // Misplaced sof realigns the frame onto channel 0.
                    wr_en[0]   = 1'b1;
                    sync_err_d = 1'b1;
                    slot_d     = SW'(1);
                end else if (acc) begin
                    wr_en[slot_q] = 1'b1;
                    slot_d        = slot_q + SW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign slot     = slot_q;
    assign sync_err = sync_err_q;

`ifdef TDM_DEMUX_PARITY_EN
    logic       par_err_q, par_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign bad = ^{in_data, in_par};

    always_comb begin
        par_err_d = acc & locked & bad;
        err_cnt_d = err_cnt_q;
        if (par_err_d && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            par_err_q <= par_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign par_err = par_err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_par;

    assign unused_par = in_par;
    assign bad        = 1'b0;
    assign par_err    = 1'b0;
    assign err_cnt    = '0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        tdm_chan_buf #(
            .WIDTH (WIDTH)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: vector table, corner sequences and random traffic
// checked against a frame-level model of the demultiplexer.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sof, in_par;
    logic [7:0]  in_data;
    logic [31:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic [1:0]  slot;
    logic        locked, sync_err, par_err;
    logic [7:0]  err_cnt;

    tdm_demux #(.WIDTH(8), .NCH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .in_par    (in_par),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err),
        .par_err   (par_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: channel contents, alignment flag, next slot.
    logic [7:0] m_d [4];
    bit   [3:0] m_v;
    int         m_slot;
    bit         m_lock, m_se, m_pe;
    int         m_cnt;
    bit         last_rdy;

    typedef struct {
        bit          v;
        bit          sof;
        logic [7:0]  d;
        logic [3:0]  ordy;
        bit          rdy;
        logic [3:0]  vld;
        logic [31:0] dat;
        int          sl;
        bit          lk;
    } vec_t;

    vec_t tbl [16];

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        n_total++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) m_d[k] = '0;
        m_v    = '0;
        m_slot = 0;
        m_lock = 0;
        m_se   = 0;
        m_pe   = 0;
        m_cnt  = 0;
    endfunction

    task automatic check_outs(string tag);
        logic [31:0] e;
        for (int k = 0; k < 4; k++) e[k*8 +: 8] = m_d[k];
        chk({tag, "_vld"}, out_valid, m_v);
        chk({tag, "_dat"}, out_data, e);
        chk({tag, "_slot"}, slot, m_slot);
        chk({tag, "_lock"}, locked, m_lock);
        chk({tag, "_serr"}, sync_err, m_se);
        chk({tag, "_perr"}, par_err, m_pe);
        chk({tag, "_ecnt"}, err_cnt, m_cnt);
    endtask

    task automatic cyc(input bit v, input bit sof, input logic [7:0] d,
                       input bit p, input logic [3:0] ordy);
        bit rdy, b;
        in_valid  = v;
        in_sof    = sof;
        in_data   = d;
        in_par    = p;
        out_ready = ordy;
        #1;
        rdy = !m_lock || !m_v[m_slot] || ordy[m_slot];
        last_rdy = in_ready;
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        #1;
        b = 0;
`ifdef TDM_DEMUX_PARITY_EN
        b = ^{d, p};
`endif
        m_se = 0;
        m_pe = 0;
        for (int k = 0; k < 4; k++) if (m_v[k] && ordy[k]) m_v[k] = 0;
        if (v && rdy) begin
            if (!m_lock) begin
                if (sof && !b) begin
                    m_d[0] = d; m_v[0] = 1; m_lock = 1; m_slot = 1;
                end
            end else if (b) begin
                m_pe = 1;
                if (m_cnt < 255) m_cnt++;
                m_slot = (m_slot + 1) % 4;
            end else if (sof && m_slot != 0) begin
                m_se = 1; m_d[0] = d; m_v[0] = 1; m_slot = 1;
            end else begin
                m_d[m_slot] = d; m_v[m_slot] = 1;
                m_slot = (m_slot + 1) % 4;
            end
        end
        check_outs("cyc");
    endtask

    task automatic do_reset();
        in_valid = 0;
        in_sof   = 0;
        rst_n    = 0;
        #1;
        model_reset();
        check_outs("rst");
        chk("rst_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[ 0] = '{1, 0, 8'h09, 4'hF, 1, 4'h0, 32'h00000000, 0, 0};
        tbl[ 1] = '{1, 0, 8'h09, 4'hF, 1, 4'h0, 32'h00000000, 0, 0};
        tbl[ 2] = '{1, 1, 8'h01, 4'hF, 1, 4'h1, 32'h00000001, 1, 1};
        tbl[ 3] = '{1, 0, 8'h02, 4'hF, 1, 4'h2, 32'h00000201, 2, 1};
        tbl[ 4] = '{1, 0, 8'h03, 4'hF, 1, 4'h4, 32'h00030201, 3, 1};
        tbl[ 5] = '{1, 0, 8'h04, 4'hF, 1, 4'h8, 32'h04030201, 0, 1};
        tbl[ 6] = '{0, 0, 8'h00, 4'hF, 1, 4'h0, 32'h04030201, 0, 1};
        tbl[ 7] = '{1, 1, 8'h01, 4'hB, 1, 4'h1, 32'h04030201, 1, 1};
        tbl[ 8] = '{1, 0, 8'h02, 4'hB, 1, 4'h2, 32'h04030201, 2, 1};
        tbl[ 9] = '{1, 0, 8'h03, 4'hB, 1, 4'h4, 32'h04030201, 3, 1};
        tbl[10] = '{1, 0, 8'h04, 4'hB, 1, 4'hC, 32'h04030201, 0, 1};
        tbl[11] = '{1, 1, 8'h05, 4'hB, 1, 4'h5, 32'h04030205, 1, 1};
        tbl[12] = '{1, 0, 8'h06, 4'hB, 1, 4'h6, 32'h04030605, 2, 1};
        tbl[13] = '{1, 0, 8'h07, 4'hB, 0, 4'h4, 32'h04030605, 2, 1};
        tbl[14] = '{1, 0, 8'h07, 4'hF, 1, 4'h4, 32'h04070605, 3, 1};
        tbl[15] = '{1, 0, 8'h08, 4'hF, 1, 4'h8, 32'h08070605, 0, 1};

        rst_n     = 1;
        in_valid  = 0;
        in_sof    = 0;
        in_data   = 0;
        in_par    = 0;
        out_ready = '0;
        model_reset();
        #2;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].v, tbl[i].sof, tbl[i].d, ^tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_rdy", i), last_rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_vld", i), out_valid, tbl[i].vld);
            chk($sformatf("tbl%0d_dat", i), out_data, tbl[i].dat);
            chk($sformatf("tbl%0d_slot", i), slot, tbl[i].sl);
            chk($sformatf("tbl%0d_lock", i), locked, tbl[i].lk);
        end

        // sof arriving at slot 2 realigns onto channel 0
        cyc(1, 1, 8'h11, 1'b0, 4'hF);
        cyc(1, 0, 8'h22, 1'b0, 4'hF);
        cyc(1, 1, 8'h33, 1'b0, 4'hF);
        chk("resync_pulse", sync_err, 1);
        chk("resync_ch0", out_data[7:0], 8'h33);
        chk("resync_slot", slot, 1);
        cyc(0, 0, 8'h00, 1'b0, 4'hF);
        chk("resync_clear", sync_err, 0);

        // channel 1 stalled holding 2, then written and drained together
        do_reset();
        cyc(1, 1, 8'h01, 1'b1, 4'hD);
        cyc(1, 0, 8'h02, 1'b1, 4'hD);
        cyc(1, 0, 8'h03, 1'b0, 4'hD);
        cyc(1, 0, 8'h04, 1'b1, 4'hD);
        cyc(1, 1, 8'h05, 1'b0, 4'hD);
        chk("wd_hold", out_data[15:8], 8'h02);
        cyc(1, 0, 8'h06, 1'b0, 4'hF);
        chk("wd_rdy", last_rdy, 1);
        chk("wd_vld", out_valid[1], 1);
        chk("wd_dat", out_data[15:8], 8'h06);

        // reset mid-frame drops buffered words and alignment
        cyc(1, 0, 8'h07, 1'b1, 4'h0);
        do_reset();
        cyc(1, 0, 8'h09, 1'b0, 4'hF);
        chk("rehunt_lock", locked, 0);
        cyc(1, 1, 8'h01, 1'b1, 4'hF);
        chk("relock", locked, 1);

`ifdef TDM_DEMUX_PARITY_EN
        do_reset();
        cyc(1, 1, 8'h01, 1'b0, 4'hF);
        chk("hunt_bad_sof", locked, 0);
        chk("hunt_no_perr", par_err, 0);
        cyc(1, 1, 8'h11, 1'b0, 4'hF);
        cyc(1, 0, 8'h03, 1'b1, 4'hF);
        chk("par_pulse", par_err, 1);
        chk("par_cnt1", err_cnt, 1);
        chk("par_nowr", out_valid[1], 0);
        chk("par_slot", slot, 2);
        for (int i = 0; i < 256; i++) cyc(1, 0, 8'h03, 1'b1, 4'hF);
        chk("par_sat", err_cnt, 255);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            bit         p;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                d = 8'($urandom);
                p = (^d) ^ ($urandom_range(0, 15) == 0);
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    d, p, 4'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
